// File: rtl/ic_bus_pkg.sv
// Shared bus definitions for CPU-port interconnect blocks.
package ic_bus_pkg;

    localparam int unsigned BusDw = 32;

    // Response beat on the CPU request/response channel (default bus width).
    typedef struct packed {
        logic             error;
        logic [BusDw-1:0] rdata;
    } bus_rsp_t;

    function automatic bit rd_lat_legal(input int unsigned lat);
        return (lat == 1) || (lat == 2);
    endfunction

    function automatic bit depth_legal(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/ic_resp_fifo.sv
// Synchronous response FIFO; pointers carry one extra bit to tell full from empty.
module ic_resp_fifo #(
    parameter int unsigned Width = 33,
    parameter int unsigned Depth = 4
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned PW   = PtrW + 1;

    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [Width-1:0] mem_q [Depth];

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                     (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign head_o  = mem_q[rptr_q[PtrW-1:0]];

    // Next pointer values.
    always_comb begin
        wptr_d = wptr_q + PW'(push_i);
        rptr_d = rptr_q + PW'(pop_i && !empty_o);
    end

    // Pointer registers.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge g_clk) begin
        if (push_i) begin
            mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
        end
    end

    // The outstanding bound upstream must keep pushes away from a full queue.
    assert property (@(posedge g_clk) disable iff (!g_resetn) !(push_i && full_o));

endmodule

// File: rtl/ic_cpu_bram_bridge_q.sv
// CPU request/response port to single-port BRAM bridge with address window,
// pipelined read latency and in-order response queueing.
module ic_cpu_bram_bridge_q
    import ic_bus_pkg::*;
#(
    parameter int unsigned    AW     = 32,
    parameter int unsigned    DW     = BusDw,
    parameter int unsigned    DEPTH  = 4,
    parameter int unsigned    RD_LAT = 1,
    parameter logic [AW-1:0]  BASE   = '0,
    parameter logic [AW-1:0]  SIZE   = 'h10000,
    localparam int unsigned   SW     = DW / 8
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          enable,
    input  logic          mem_req,
    output logic          mem_gnt,
    input  logic          mem_wen,
    input  logic [SW-1:0] mem_strb,
    input  logic [DW-1:0] mem_wdata,
    input  logic [AW-1:0] mem_addr,
    output logic          mem_recv,
    input  logic          mem_ack,
    output logic          mem_error,
    output logic [DW-1:0] mem_rdata,
    output logic          bram_cen,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_wdata,
    output logic [SW-1:0] bram_wstrb,
    input  logic          bram_stall,
    input  logic [DW-1:0] bram_rdata
);

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $fatal(1, "RD_LAT must be 1 or 2");
    end
    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $fatal(1, "DEPTH must be a power of two >= 2");
    end
    if ((DW % 8) != 0) begin : g_bad_dw
        $fatal(1, "DW must be a multiple of 8");
    end

    localparam int unsigned   OW      = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] WinMask = SIZE - AW'(1);

    // Same layout as bus_rsp_t, sized to this instance's DW.
    typedef struct packed {
        logic          error;
        logic [DW-1:0] rdata;
    } rsp_t;

    typedef struct packed {
        logic vld;
        logic err;
        logic wr;
    } tag_t;

    logic                   in_win, accept;
    logic [OW-1:0]          out_q, out_d;
    tag_t [RD_LAT-1:0]      tag_q, tag_d;
    tag_t                   tag_exit;
    rsp_t                   exit_rsp, head_rsp, rsp_out;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign in_win     = (mem_addr & ~WinMask) == BASE;
    assign mem_gnt    = enable && !bram_stall && (out_q < OW'(DEPTH));
    assign accept     = mem_req && mem_gnt;
    assign bram_cen   = accept && in_win;
    assign bram_addr  = mem_addr - BASE;
    assign bram_wdata = mem_wdata;
    assign bram_wstrb = mem_wen ? mem_strb : '0;

    // Tag pipeline tracks each accept alongside the BRAM read latency.
    always_comb begin
        tag_d        = tag_q;
        tag_d[0].vld = accept;
        tag_d[0].err = !in_win;
        tag_d[0].wr  = mem_wen;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        out_d = out_q + OW'(accept) - OW'(mem_recv && mem_ack);
    end

    // Tag pipeline and outstanding counter registers.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            tag_q <= '0;
            out_q <= '0;
        end else begin
            tag_q <= tag_d;
            out_q <= out_d;
        end
    end

    // Response formation, bypass mux and queue control.
    always_comb begin
        tag_exit       = tag_q[RD_LAT-1];
        exit_rsp.error = tag_exit.err;
        exit_rsp.rdata = (tag_exit.err || tag_exit.wr) ? '0 : bram_rdata;
        // Queue only when something is already waiting or the CPU stalls us.
        fifo_push      = tag_exit.vld && (!fifo_empty || !mem_ack);
        fifo_pop       = !fifo_empty && mem_ack;
        mem_recv       = !fifo_empty || tag_exit.vld;
        rsp_out        = '0;
        if (!fifo_empty) begin
            rsp_out = head_rsp;
        end else if (tag_exit.vld) begin
            rsp_out = exit_rsp;
        end
    end

    assign mem_error = rsp_out.error;
    assign mem_rdata = rsp_out.rdata;

    ic_resp_fifo #(
        .Width (DW + 1),
        .Depth (DEPTH)
    ) u_resp_fifo (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .push_i   (fifo_push),
        .pop_i    (fifo_pop),
        .wdata_i  (exit_rsp),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .head_o   (head_rsp)
    );

    // Full flag is consumed only by the queue's own overflow assertion.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_ic_cpu_bram_bridge_q.sv
// Scoreboard bench for ic_cpu_bram_bridge_q (RD_LAT=2, DEPTH=4, window 0x10000..0x1FFFF).
module tb_ic_cpu_bram_bridge_q;

    localparam int unsigned LAT  = 2;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] SIZE = 32'h0001_0000;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        enable = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_gnt;
    logic        mem_wen = 1'b0;
    logic [3:0]  mem_strb = 4'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_addr = 32'h0;
    logic        mem_recv;
    logic        mem_ack = 1'b1;
    logic        mem_error;
    logic [31:0] mem_rdata;
    logic        bram_cen;
    logic [31:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [3:0]  bram_wstrb;
    logic        bram_stall = 1'b0;
    logic [31:0] bram_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 g_clk = ~g_clk;

    ic_cpu_bram_bridge_q #(
        .AW     (32),
        .DW     (32),
        .DEPTH  (4),
        .RD_LAT (LAT),
        .BASE   (BASE),
        .SIZE   (SIZE)
    ) u_dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .enable     (enable),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_wen    (mem_wen),
        .mem_strb   (mem_strb),
        .mem_wdata  (mem_wdata),
        .mem_addr   (mem_addr),
        .mem_recv   (mem_recv),
        .mem_ack    (mem_ack),
        .mem_error  (mem_error),
        .mem_rdata  (mem_rdata),
        .bram_cen   (bram_cen),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_wstrb (bram_wstrb),
        .bram_stall (bram_stall),
        .bram_rdata (bram_rdata)
    );

    // BRAM model: preloaded words, byte-strobed writes, LAT-cycle read pipe.
    logic [31:0] bmem [16384];
    logic [31:0] rd_p0, rd_p1;
    logic        preload = 1'b1;

    always @(posedge g_clk) begin
        if (preload) begin
            bmem[0]      <= 32'h1111_0000;
            bmem[1]      <= 32'h2222_0004;
            bmem[2]      <= 32'h3333_0008;
            bmem[3]      <= 32'h4444_000C;
            bmem[4]      <= 32'hCAFE_F00D;
            bmem[5]      <= 32'h5555_0014;
            bmem[6]      <= 32'h6666_0018;
            bmem[8]      <= 32'hDEAD_BEEF;
            bmem[16383]  <= 32'h0000_0000;
        end else if (bram_cen) begin
            for (int b = 0; b < 4; b++) begin
                if (bram_wstrb[b]) bmem[bram_addr[15:2]][b*8 +: 8] <= bram_wdata[b*8 +: 8];
            end
        end
        rd_p0 <= (bram_cen && bram_wstrb == 4'h0) ? bmem[bram_addr[15:2]] : 32'hBAD0_BAD0;
        rd_p1 <= rd_p0;
    end
    assign bram_rdata = (LAT == 1) ? rd_p0 : rd_p1;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
        bit          lat;
    } exp_t;

    vec_t vecs [24];
    exp_t sb [$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter, read only at negedges.
    initial forever begin
        @(posedge g_clk);
        cyc++;
    end

    // Monitor: every consumed response is matched against the scoreboard head.
    initial forever begin
        @(negedge g_clk);
        if (g_resetn && mem_recv && mem_ack) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=err%0d/%h required=no response",
                         mem_error, mem_rdata);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_error", {31'b0, mem_error}, {31'b0, mon_e.err});
                chk("rsp_rdata", mem_rdata, mon_e.rdata);
                if (mon_e.lat) chk("latency", cyc - mon_e.acc, LAT);
            end
        end
    end

    // Issue vecs[first..first+n-1]; mem_ack is held low for the first ack_low cycles.
    task automatic stream(input int first, input int n, input int ack_low, output int used,
                          output int low_grants, output logic last_low_gnt);
        int idx = first;
        int c = 0;
        low_grants = 0;
        last_low_gnt = 1'b0;
        while (idx < first + n && c < 60) begin
            mem_ack   = (c >= ack_low);
            mem_req   = 1'b1;
            mem_addr  = vecs[idx].addr;
            mem_wen   = vecs[idx].wen;
            mem_strb  = vecs[idx].strb;
            mem_wdata = vecs[idx].wdata;
            @(negedge g_clk);
            if (c < ack_low) last_low_gnt = mem_gnt;
            if (mem_gnt) begin
                chk("bram_cen", {31'b0, bram_cen}, {31'b0, !vecs[idx].err});
                chk("bram_wstrb", {28'b0, bram_wstrb},
                    {28'b0, vecs[idx].wen ? vecs[idx].strb : 4'h0});
                if (!vecs[idx].err) chk("bram_addr", bram_addr, vecs[idx].addr - BASE);
                sb.push_back('{err: vecs[idx].err, rdata: vecs[idx].rdata, acc: cyc,
                               lat: (ack_low == 0)});
                if (c < ack_low) low_grants++;
                idx++;
            end
            @(posedge g_clk);
            #1;
            c++;
        end
        mem_req = 1'b0;
        mem_wen = 1'b0;
        if (idx < first + n) begin
            checks++;
            failures++;
            $display("FAIL stream_timeout actual=%0d granted required=%0d", idx - first, n);
        end
        used = c;
    endtask

    task automatic drain();
        int n = 0;
        mem_ack = 1'b1;
        while (sb.size() != 0 && n < 50) begin
            @(posedge g_clk);
            #1;
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   used, lowg, stale;
        logic lastg;
        //          addr           wen   strb  wdata          err   rdata
        vecs[0]  = '{32'h0001_0010, 1'b0, 4'h0, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[1]  = '{32'h0001_0000, 1'b0, 4'h0, 32'h0,         1'b0, 32'h1111_0000};
        vecs[2]  = '{32'h0001_0004, 1'b0, 4'h0, 32'h0,         1'b0, 32'h2222_0004};
        vecs[3]  = '{32'h0001_0008, 1'b0, 4'h0, 32'h0,         1'b0, 32'h3333_0008};
        vecs[4]  = '{32'h0001_000C, 1'b0, 4'h0, 32'h0,         1'b0, 32'h4444_000C};
        vecs[5]  = '{32'h0001_0020, 1'b1, 4'h3, 32'h1122_3344, 1'b0, 32'h0};
        vecs[6]  = '{32'h0001_0020, 1'b0, 4'h0, 32'h0,         1'b0, 32'hDEAD_3344};
        vecs[7]  = '{32'h0002_0000, 1'b0, 4'h0, 32'h0,         1'b1, 32'h0};
        vecs[8]  = '{32'h0000_FFFC, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[9]  = '{32'h0001_0014, 1'b0, 4'h0, 32'h0,         1'b0, 32'h5555_0014};
        vecs[10] = '{32'h0001_0018, 1'b0, 4'h0, 32'h0,         1'b0, 32'h6666_0018};
        vecs[11] = '{32'h0001_0010, 1'b0, 4'h0, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[12] = '{32'h0001_0004, 1'b1, 4'hC, 32'hAABB_CCDD, 1'b0, 32'h0};
        vecs[13] = '{32'h0001_0004, 1'b0, 4'h0, 32'h0,         1'b0, 32'hAABB_0004};
        vecs[14] = '{32'h0001_FFFC, 1'b0, 4'h0, 32'h0,         1'b0, 32'h0};
        vecs[15] = '{32'h0001_0008, 1'b0, 4'h0, 32'h0,         1'b0, 32'h3333_0008};
        vecs[16] = '{32'h0002_FFFC, 1'b0, 4'h0, 32'h0,         1'b1, 32'h0};
        vecs[17] = '{32'h0001_000C, 1'b0, 4'h0, 32'h0,         1'b0, 32'h4444_000C};
        vecs[18] = '{32'h0001_0014, 1'b0, 4'h0, 32'h0,         1'b0, 32'h5555_0014};
        vecs[19] = '{32'h0001_0000, 1'b0, 4'h0, 32'h0,         1'b0, 32'h1111_0000};
        vecs[20] = '{32'h0001_0020, 1'b0, 4'h0, 32'h0,         1'b0, 32'hDEAD_3344};
        vecs[21] = '{32'h0001_0018, 1'b0, 4'h0, 32'h0,         1'b0, 32'h6666_0018};
        vecs[22] = '{32'h0003_0000, 1'b0, 4'h0, 32'h0,         1'b1, 32'h0};
        vecs[23] = '{32'h0001_0004, 1'b0, 4'h0, 32'h0,         1'b0, 32'hAABB_0004};

        // Reset state.
        repeat (3) @(posedge g_clk);
        #1;
        preload = 1'b0;
        @(negedge g_clk);
        chk("rst_recv", {31'b0, mem_recv}, 32'h0);
        chk("rst_error", {31'b0, mem_error}, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_cen", {31'b0, bram_cen}, 32'h0);
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        @(negedge g_clk);
        chk("rst_gnt", {31'b0, mem_gnt}, 32'h1);
        @(posedge g_clk);
        #1;

        // Single read, then back-to-back reads, then write/readback and window errors.
        stream(0, 1, 0, used, lowg, lastg);
        drain();
        stream(1, 4, 0, used, lowg, lastg);
        chk("b2b_cycles", used, 4);
        drain();
        stream(5, 4, 0, used, lowg, lastg);
        chk("mixed_cycles", used, 4);
        drain();

        // Back-pressure: six requests against a four-deep bound.
        stream(9, 6, 8, used, lowg, lastg);
        chk("bp_grants", lowg, 4);
        chk("bp_gnt_low", {31'b0, lastg}, 32'h0);
        drain();

        // Stall then enable low: no grants, queued responses still drain.
        stream(15, 2, 100, used, lowg, lastg);
        mem_req  = 1'b1;
        mem_addr = 32'h0001_0000;
        bram_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge g_clk);
            chk("stall_gnt", {31'b0, mem_gnt}, 32'h0);
            @(posedge g_clk);
            #1;
        end
        bram_stall = 1'b0;
        enable     = 1'b0;
        mem_ack    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge g_clk);
            chk("disable_gnt", {31'b0, mem_gnt}, 32'h0);
            @(posedge g_clk);
            #1;
        end
        chk("disable_drained", sb.size(), 0);
        mem_req = 1'b0;
        enable  = 1'b1;
        drain();

        // Reset with three outstanding: everything in flight is discarded.
        stream(17, 3, 100, used, lowg, lastg);
        g_resetn = 1'b0;
        @(posedge g_clk);
        #1;
        sb.delete();
        @(negedge g_clk);
        chk("midrst_recv", {31'b0, mem_recv}, 32'h0);
        chk("midrst_outstanding", {29'b0, u_dut.out_q}, 32'h0);
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        mem_ack  = 1'b1;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge g_clk);
            if (mem_recv) stale++;
            @(posedge g_clk);
            #1;
        end
        chk("no_stale", stale, 0);
        stream(20, 4, 100, used, lowg, lastg);
        chk("post_rst_grants", used, 4);
        mem_req  = 1'b1;
        mem_addr = 32'h0001_0000;
        @(negedge g_clk);
        chk("depth_full_gnt", {31'b0, mem_gnt}, 32'h0);
        @(posedge g_clk);
        #1;
        mem_req = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ic_cpu_bram_bridge_q.md
# ic_cpu_bram_bridge_q

Parametrised bridge between a CPU request/response bus channel (instruction or data port) and a single-port BRAM, with configurable BRAM read latency, N-deep outstanding-request buffering and an address window that returns bus errors for out-of-range accesses. It sits in the interconnect between each CPU port and its local memory. Unlike a single-entry skid buffer, it sustains one request per cycle under response back-pressure until the response queue is full.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; multiple of 8; strobe width SW = DW/8
- DEPTH, 4, max outstanding requests and response queue depth; power of two, >= 2
- RD_LAT, 1, BRAM read latency in cycles; 1 or 2
- BASE, 0, window base address, aligned to SIZE
- SIZE, 'h10000, window size in bytes; power of two

Ports:
- g_clk  in  1  clock; reset g_resetn, synchronous, active-low; clock g_clk
- g_resetn  in  1  synchronous active-low reset
- enable  in  1  allow new grants
- mem_req  in  1  request valid
- mem_gnt  out  1  request accepted this cycle
- mem_wen  in  1  write enable
- mem_strb  in  SW  byte write strobe
- mem_wdata  in  DW  write data
- mem_addr  in  AW  byte address
- mem_recv  out  1  response valid
- mem_ack  in  1  response accepted
- mem_error  out  1  response is an error
- mem_rdata  out  DW  read data; 0 for writes and errors
- bram_cen  out  1  BRAM access strobe
- bram_addr  out  AW  offset (mem_addr - BASE)
- bram_wdata  out  DW  write data
- bram_wstrb  out  SW  mem_wen ? mem_strb : 0
- bram_stall  in  1  BRAM cannot accept this cycle
- bram_rdata  in  DW  read data, valid RD_LAT cycles after accepted bram_cen

## Operation
- in_win = (mem_addr & ~(SIZE-1)) == BASE.
- mem_gnt = enable && !bram_stall && (outstanding < DEPTH). Accept = mem_req && mem_gnt.
- bram_cen = accept && in_win. Out-of-window accepts do not touch the BRAM.
- Each accept enters an RD_LAT-stage tag pipeline carrying {valid, error = !in_win, is_write}.
- At pipeline exit: response = {error, rdata = (error || is_write) ? 0 : bram_rdata}.
- Bypass: queue empty -> the exiting response drives mem_recv/mem_rdata/mem_error directly; if mem_ack is low it is pushed into the queue.
- Queue non-empty -> mem_recv = 1, outputs from head, pop on mem_ack; an exiting response is pushed behind. Responses are strictly in request order.
- outstanding: +1 on accept, -1 on (mem_recv && mem_ack); both together -> unchanged. Width clog2(DEPTH+1). The bound on outstanding guarantees the queue never overflows; a push to a full queue is a design error (assertion).
- mem_ack without mem_recv is ignored.
- enable low blocks new grants only; in-flight responses still drain.

## Timing
- Reset values: mem_recv=0, mem_error=0, mem_rdata=0, bram_cen=0, outstanding=0, queue empty, tag pipeline cleared. mem_gnt = enable && !bram_stall once reset releases.
- Reset asserted mid-operation: all in-flight and queued responses are discarded; no response is produced for them after reset.
- Accept at cycle T -> mem_recv earliest at T+RD_LAT (combinational bypass from bram_rdata).
- Throughput: 1 request/cycle while mem_ack is held high.
- mem_gnt, bram_* are combinational from inputs and registered state. mem_recv/mem_rdata/mem_error depend only on registered state and bram_rdata, never on mem_ack.
- mem_ack low -> at most DEPTH accepts, then mem_gnt=0 until a pop.

## Structure
- Shared package ic_bus_pkg: bus response struct {error, rdata}, and the RD_LAT and DEPTH legality checks as elaboration-time assertions.
- Sub-module ic_resp_fifo: synchronous FIFO, DEPTH x (DW+1), with push, pop, full, empty and head outputs. Pointer wrap uses one extra pointer bit.
- Top level holds the window decode, tag pipeline, outstanding counter and bypass mux.

## Test plan
- RD_LAT=1, read 0x10 with BRAM word 0xCAFEF00D, mem_ack tied high -> mem_recv at T+1, rdata 0xCAFEF00D, error 0.
- RD_LAT=2, 4 back-to-back reads with mem_ack high -> 4 consecutive responses at T+2..T+5, in order, mem_gnt never drops.
- DEPTH=4, mem_ack low, 6 requests -> exactly 4 grants, then mem_gnt=0. Raise mem_ack -> 4 in-order responses, then the remaining 2 are granted.
- Access to BASE+SIZE -> bram_cen=0, response error=1, rdata 0. Write with strb 0x3 -> bram_wstrb=0x3, response rdata 0.
- Pulse bram_stall high for 3 cycles, then enable low -> mem_gnt=0 throughout both; queued responses still drain.
- Assert g_resetn low with 3 requests outstanding -> next cycle mem_recv=0 and outstanding=0; no stale response appears after reset release.
